// File: rtl/pipe_input_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered pipeline input stage; 1-cycle latency.
// A stalled, occupied output stage holds its beat and withdraws every req_ready.
module pipe_input_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      pipe_stall,
    output logic [DATA_W-1:0]         pipe_data,
    output logic                      pipe_en,
    output logic [TAG_W-1:0]          pipe_tag,
    output logic                      pipe_last,
    output logic                      locked
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]    owner_q, owner_d;
    logic [DATA_W-1:0]   pipe_data_q, pipe_data_d;
    logic [TAG_W-1:0]    pipe_tag_q, pipe_tag_d;
    logic                pipe_en_q, pipe_en_d;
    logic                pipe_last_q, pipe_last_d;

    logic                load;
    logic [2*N_REQ-1:0]  valid_dbl, valid_shift;
    logic [N_REQ-1:0]    valid_rot;
    logic [TAG_W:0]      sum;
    logic [TAG_W-1:0]    winner, sel, next_ptr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last, sel_valid, accept;

    assign load        = !pipe_en_q || !pipe_stall;
    assign valid_dbl   = {req_valid, req_valid};
    assign valid_shift = valid_dbl >> rr_ptr_q;
    assign valid_rot   = valid_shift[N_REQ-1:0];

    // Rotated view puts rr_ptr at bit 0; scanning downward leaves the lowest offset as winner.
    always_comb begin
        sum    = '0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                sum = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
                if (sum >= (TAG_W+1)'(N_REQ))
                    sum = sum - (TAG_W+1)'(N_REQ);
                winner = sum[TAG_W-1:0];
            end
        end
    end

    assign sel      = (state_q == LOCK) ? owner_q : winner;
    assign next_ptr = (sel == TAG_W'(N_REQ - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == TAG_W'(k)) begin
                sel_data  = req_data[k*DATA_W +: DATA_W];
                sel_last  = req_last[k];
                sel_valid = req_valid[k];
            end
        end
    end

    assign accept = load && sel_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            pipe_data_q <= '0;
            pipe_tag_q  <= '0;
            pipe_en_q   <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            pipe_data_q <= pipe_data_d;
            pipe_tag_q  <= pipe_tag_d;
            pipe_en_q   <= pipe_en_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        pipe_data_d = pipe_data_q;
        pipe_tag_d  = pipe_tag_q;
        pipe_en_d   = pipe_en_q;
        pipe_last_d = pipe_last_q;
        if (accept) begin
            if (sel_last) begin
                state_d  = ARB;
                rr_ptr_d = next_ptr;
            end else begin
                state_d  = LOCK;
                owner_d  = sel;
            end
        end
        // A load with nothing accepted leaves a bubble; data/tag keep their last values.
        if (load) begin
            pipe_en_d   = accept;
            pipe_last_d = accept && sel_last;
            if (accept) begin
                pipe_data_d = sel_data;
                pipe_tag_d  = sel;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++)
            req_ready[k] = accept && (sel == TAG_W'(k));
        locked = (state_q == LOCK);
    end

    assign pipe_data = pipe_data_q;
    assign pipe_en   = pipe_en_q;
    assign pipe_tag  = pipe_tag_q;
    assign pipe_last = pipe_last_q;

endmodule

// File: tb/tb_pipe_input_arbiter.sv
// Directed bench for pipe_input_arbiter: expected beats are queued at handshake and checked on output.
module tb_pipe_input_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [127:0]  req_data = '0;
    logic [3:0]    req_last = '0;
    logic [3:0]    req_ready;
    logic          pipe_stall = 1'b0;
    logic [31:0]   pipe_data;
    logic          pipe_en;
    logic [1:0]    pipe_tag;
    logic          pipe_last;
    logic          locked;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  tag;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t cur;
    logic  exp_en = 1'b0;
    int    checks = 0;
    int    failures = 0;

    pipe_input_arbiter #(.N_REQ(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .pipe_stall(pipe_stall), .pipe_data(pipe_data), .pipe_en(pipe_en),
        .pipe_tag(pipe_tag), .pipe_last(pipe_last), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check at negedge, advance the output model at posedge.
    task automatic cycle(input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic st, input logic [3:0] rdy, input logic lk);
        beat_t b;
        req_valid  = v;
        req_last   = l;
        req_data   = {d3, d2, d1, d0};
        pipe_stall = st;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(rdy));
        chk("locked", 64'(locked), 64'(lk));
        chk("pipe_en", 64'(pipe_en), 64'(exp_en));
        if (exp_en) begin
            chk("pipe_data", 64'(pipe_data), 64'(cur.data));
            chk("pipe_tag", 64'(pipe_tag), 64'(cur.tag));
            chk("pipe_last", 64'(pipe_last), 64'(cur.last));
        end
        if (rdy != 4'b0000) begin
            case (rdy)
                4'b0001: b = '{data: d0, tag: 2'd0, last: l[0]};
                4'b0010: b = '{data: d1, tag: 2'd1, last: l[1]};
                4'b0100: b = '{data: d2, tag: 2'd2, last: l[2]};
                default: b = '{data: d3, tag: 2'd3, last: l[3]};
            endcase
            sb.push_back(b);
        end
        @(posedge clk);
        if (!exp_en || !st) begin
            if (sb.size() > 0) begin
                cur    = sb.pop_front();
                exp_en = 1'b1;
            end else begin
                exp_en = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] rdy_unused);
        cycle(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, rdy_unused, 1'b0);
    endtask

    initial begin
        // Reset: ready stays low even with every requester valid.
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_en", 64'(pipe_en), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_data", 64'(pipe_data), 64'(0));
        chk("rst_tag", 64'(pipe_tag), 64'(0));
        chk("rst_last", 64'(pipe_last), 64'(0));
        req_valid = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) idle(4'b0000);

        // Req0 single beats 9, 2, bubble, 13
        cycle(4'b0001, 4'b0001, 9, 0, 0, 0, 1'b0, 4'b0001, 1'b0);
        cycle(4'b0001, 4'b0001, 2, 0, 0, 0, 1'b0, 4'b0001, 1'b0);
        cycle(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, 4'b0000, 1'b0);
        cycle(4'b0001, 4'b0001, 13, 0, 0, 0, 1'b0, 4'b0001, 1'b0);
        idle(4'b0000);

        // Req1 / req3 alternate; pointer runs 1 -> 2 -> 0 -> 2 -> 0
        for (int n = 0; n < 4; n++)
            cycle(4'b1010, 4'b1010, 0, 32'h100 + n, 0, 32'h300 + n, 1'b0,
                  (n % 2 == 0) ? 4'b0010 : 4'b1000, 1'b0);
        idle(4'b0000);

        // Req2 3-beat packet with a mid-packet gap; req0 waits until it ends
        cycle(4'b0100, 4'b0000, 0, 0, 32'hA, 0, 1'b0, 4'b0100, 1'b0);
        cycle(4'b0101, 4'b0001, 32'h77, 0, 32'hB, 0, 1'b0, 4'b0100, 1'b1);
        cycle(4'b0001, 4'b0001, 32'h77, 0, 0, 0, 1'b0, 4'b0000, 1'b1);
        cycle(4'b0101, 4'b0101, 32'h77, 0, 32'hC, 0, 1'b0, 4'b0100, 1'b1);
        cycle(4'b0001, 4'b0001, 32'h77, 0, 0, 0, 1'b0, 4'b0001, 1'b0);
        idle(4'b0000);

        // Stall holds 0x55 for three cycles; req1 is served once it drops
        cycle(4'b0001, 4'b0001, 32'h55, 0, 0, 0, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(4'b0010, 4'b0010, 0, 32'h66, 0, 0, 1'b1, 4'b0000, 1'b0);
        cycle(4'b0010, 4'b0010, 0, 32'h66, 0, 0, 1'b0, 4'b0010, 1'b0);
        idle(4'b0000);
        idle(4'b0000);

        // Req1 4-beat packet interrupted by reset after beat 2
        cycle(4'b0010, 4'b0000, 0, 32'h201, 0, 0, 1'b0, 4'b0010, 1'b0);
        cycle(4'b0010, 4'b0000, 0, 32'h202, 0, 0, 1'b0, 4'b0010, 1'b1);
        chk("pre_rst_en", 64'(pipe_en), 64'(1));
        chk("pre_rst_locked", 64'(locked), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", 64'(pipe_en), 64'(0));
        chk("async_rst_locked", 64'(locked), 64'(0));
        chk("async_rst_ready", 64'(req_ready), 64'(0));
        sb.delete();
        exp_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Pointer back at 0: req0 wins, then req1 restarts its packet
        cycle(4'b0011, 4'b0001, 32'h301, 32'h201, 0, 0, 1'b0, 4'b0001, 1'b0);
        cycle(4'b0010, 4'b0000, 0, 32'h201, 0, 0, 1'b0, 4'b0010, 1'b0);
        cycle(4'b0010, 4'b0000, 0, 32'h202, 0, 0, 1'b0, 4'b0010, 1'b1);
        cycle(4'b0010, 4'b0000, 0, 32'h203, 0, 0, 1'b0, 4'b0010, 1'b1);
        cycle(4'b0010, 4'b0010, 0, 32'h204, 0, 0, 1'b0, 4'b0010, 1'b1);
        idle(4'b0000);
        idle(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_input_arbiter.md
Name: pipe_input_arbiter

Overview:
- Shares the single 32-bit pipeline input (data plus enable, the interface driven into generated pipelines) between N_REQ requesters.
- Round-robin arbitration at packet granularity: a requester keeps the grant until it transfers a beat with `req_last` set.
- Output stage is registered, with a tag identifying the source requester.
- A downstream stall input holds the output stage.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 32, data width
- TAG_W, $clog2(N_REQ) (minimum 1), width of source tag

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  beat is last of packet
- req_ready  out  N_REQ  beat accepted this cycle (combinational)
- pipe_stall  in  1  downstream cannot take the current output beat
- pipe_data  out  DATA_W  registered pipeline data
- pipe_en  out  1  registered pipeline enable (data valid)
- pipe_tag  out  TAG_W  index of requester that produced pipe_data
- pipe_last  out  1  registered copy of req_last
- locked  out  1  a packet is in progress (FSM in LOCK)

Behaviour:
- Reset (async assert, sync release):
  - pipe_en=0, pipe_last=0, pipe_data=0, pipe_tag=0.
  - rr_ptr=0, FSM=ARB, locked=0.
  - req_ready=0 while rst is high.
- load = !pipe_en || !pipe_stall. The output register accepts a new beat only when load is 1.
- When pipe_en=1 and pipe_stall=1:
  - pipe_data, pipe_tag, pipe_last and pipe_en hold their values.
  - All req_ready=0.
- FSM ARB:
  - winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo N_REQ (wrap from N_REQ-1 to 0).
  - If any valid and load: req_ready[winner]=1 and the beat is registered the next edge (pipe_en=1, pipe_tag=winner).
  - If that beat has last=0: go to LOCK with owner=winner.
  - If last=1: stay in ARB and set rr_ptr=(winner+1) mod N_REQ.
  - If no valid and load: pipe_en=0 next cycle.
- FSM LOCK:
  - Only the owner is eligible. req_ready[owner] = req_valid[owner] && load.
  - If the owner has no valid beat and load=1: emit a bubble (pipe_en=0). Other requesters stay blocked.
  - An accepted beat with last=1 returns the FSM to ARB and sets rr_ptr=(owner+1) mod N_REQ.
- Latency:
  - Accepted beat appears on pipe_* one cycle after the req_ready/req_valid cycle.
  - Full throughput: 1 beat/cycle with no stall.
- A single-beat packet (last=1 on the first beat) never enters LOCK.
- At most one req_ready bit is set in any cycle (one-hot or zero).
- Reset mid-packet:
  - Lock is dropped, rr_ptr=0, and the output beat is discarded.
  - The requester must restart its packet.
- req_valid deasserting without a handshake is tolerated; the arbiter does not latch requests.

Test Plan:
- Reset then idle, all req_valid=0 for 10 cycles -> pipe_en=0 and req_ready=0 throughout; locked=0.
- Req0 sends single beats 9, 2, then a bubble, then 13 (last=1 each), no stall -> pipe_data 9, 2, (en=0), 13 on consecutive cycles, each one cycle after its handshake; pipe_tag=0.
- Req1 and req3 both continuously valid with single-beat packets (data 0x100+n and 0x300+n) -> grants alternate 1, 3, 1, 3; rr_ptr wraps 3->0; pipe_tag sequence 1, 3, 1, 3.
- Req2 sends a 3-beat packet (0xA, 0xB, 0xC with last on 0xC) while req0 is valid; req2 drops valid for one cycle mid-packet -> output 0xA, 0xB, bubble, 0xC all tag 2, locked=1 until after 0xC; req0 is granted only after 0xC.
- pipe_stall=1 for 3 cycles while pipe_data=0x55 -> 0x55/tag/en held, all req_ready=0; the next beat appears on the first cycle after stall drops.
- Assert rst during a req1 4-beat packet after beat 2 -> pipe_en=0 and locked=0 immediately (asynchronous); after release, req0 and req1 both valid -> req0 granted first (rr_ptr=0).
